// File: rtl/jtframe_ram_streamer.sv
// Sequential RAM window reader that streams words out over valid/ready.
// Define JTFRAME_RAM_STREAM_CHKSUM_EN to add the running checksum port chk_o.

// Generic FIFO with registered storage, cleared on reset.
// Latency: a pushed word appears at dout_o the cycle after the push.
// Backpressure: a push while full is dropped unless a pop happens in the same cycle.
module jtframe_ram_streamer_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [W-1:0]               din_i,
    input  logic                       pop_i,
    output logic [W-1:0]               dout_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] rd_q, wr_q;
    logic [CW-1:0] cnt_q;
    logic          wr_en, rd_en;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign count_o = cnt_q;
    assign dout_o  = mem_q[rd_q];
    assign rd_en   = pop_i && !empty_o;
    assign wr_en   = push_i && (!full_o || rd_en);

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wr_q] <= din_i;
                wr_q        <= nxt(wr_q);
            end
            if (rd_en) rd_q <= nxt(rd_q);
            cnt_q <= cnt_q + CW'(wr_en) - CW'(rd_en);
        end
    end
endmodule

// Walks base..base+len-1 (wrapping) on a 1-cycle-latency RAM port into a 2-deep FIFO.
// Latency: start at S gives ram_addr=base at S+1 and first dout_valid at S+3; 1 word/cycle.
// Backpressure: reads stop once FIFO plus in-flight reach 2; outputs hold while stalled.
module jtframe_ram_streamer #(
    parameter int DW = 8,
    parameter int AW = 10
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic [AW-1:0] base_i,
    input  logic [AW:0]   len_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [AW-1:0] ram_addr_o,
    input  logic [DW-1:0] ram_q_i,
    output logic [DW-1:0] dout_o,
    output logic          dout_valid_o,
    input  logic          dout_ready_i,
    output logic          dout_last_o
`ifdef JTFRAME_RAM_STREAM_CHKSUM_EN
    ,
    output logic [DW-1:0] chk_o
`endif
);
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;
    typedef struct packed {
        logic          last;
        logic [DW-1:0] dat;
    } word_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q;
    logic [AW:0]   len_q, issue_cnt_q;
    logic          cap_q, cap_last_q, done_q;
    logic          start_ok, start_run, issue, last_issue, pop, last_pop;
    logic          fifo_empty, fifo_full;
    logic [1:0]    fifo_cnt;
    logic [2:0]    occ;
    word_t         head;

    assign start_ok   = (state_q == ST_IDLE) && start_i;
    assign start_run  = start_ok && (len_i != '0);
    assign last_issue = ((issue_cnt_q + 1'b1) == len_q);
    assign pop        = dout_valid_o && dout_ready_i;
    assign last_pop   = (state_q == ST_DRAIN) && pop && head.last;
    // Counts the word whose data sits on ram_q this cycle; it lands in the FIFO at this edge.
    assign occ        = {1'b0, fifo_cnt} + {2'b0, cap_q} - {2'b0, pop};

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_run)            state_d = ST_RUN;
            ST_RUN:   if (issue && last_issue)  state_d = ST_DRAIN;
            ST_DRAIN: if (last_pop)             state_d = ST_IDLE;
            default:                            state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state_q != ST_IDLE);
        issue  = (state_q == ST_RUN) && (occ < 3'd2);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q      <= '0;
            len_q       <= '0;
            issue_cnt_q <= '0;
            cap_q       <= 1'b0;
            cap_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            cap_q      <= issue;
            cap_last_q <= issue && last_issue;
            done_q     <= (start_ok && (len_i == '0)) || last_pop;
            if (start_run) begin
                addr_q      <= base_i;
                len_q       <= len_i;
                issue_cnt_q <= '0;
            end else if (issue) begin
                addr_q      <= addr_q + 1'b1;
                issue_cnt_q <= issue_cnt_q + 1'b1;
            end
        end
    end

    jtframe_ram_streamer_fifo #(.W(DW + 1), .DEPTH(2)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (cap_q),
        .din_i   ({cap_last_q, ram_q_i}),
        .pop_i   (pop),
        .dout_o  (head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (fifo_cnt)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(cap_q && fifo_full));
        end
    end

    assign ram_addr_o   = addr_q;
    assign done_o       = done_q;
    assign dout_valid_o = !fifo_empty;
    assign dout_o       = head.dat;
    assign dout_last_o  = dout_valid_o && head.last;

`ifdef JTFRAME_RAM_STREAM_CHKSUM_EN
    logic [DW-1:0] chk_q;
    always_ff @(posedge clk_i) begin
        if (rst_i || start_ok) chk_q <= '0;
        else if (pop)          chk_q <= chk_q + head.dat;
    end
    assign chk_o = chk_q;
`endif
endmodule

// File: tb/tb_jtframe_ram_streamer.sv
// Directed bench for jtframe_ram_streamer against a preloaded 1-cycle-latency RAM model.
module tb_jtframe_ram_streamer;
    logic        clk = 1'b0;
    logic        rst, start, busy, done, dout_valid, dout_ready, dout_last;
    logic [9:0]  base, ram_addr;
    logic [10:0] len;
    logic [7:0]  ram_q, dout;
`ifdef JTFRAME_RAM_STREAM_CHKSUM_EN
    logic [7:0]  chk;
`endif
    logic [7:0]  mem [1024];
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    always @(posedge clk) ram_q <= mem[ram_addr];

    jtframe_ram_streamer #(.DW(8), .AW(10)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .base_i       (base),
        .len_i        (len),
        .busy_o       (busy),
        .done_o       (done),
        .ram_addr_o   (ram_addr),
        .ram_q_i      (ram_q),
        .dout_o       (dout),
        .dout_valid_o (dout_valid),
        .dout_ready_i (dout_ready),
        .dout_last_o  (dout_last)
`ifdef JTFRAME_RAM_STREAM_CHKSUM_EN
        ,
        .chk_o        (chk)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Pulses start for one cycle (S); returns at the negedge of S+1.
    task automatic do_start(input logic [9:0] b, input logic [10:0] l);
        @(negedge clk);
        start = 1'b1;
        base  = b;
        len   = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    logic [9:0] t2_addr [4];
    logic [7:0] t2_dat  [4];
    logic       pat     [7];
    int         acc, words, dones, quiet;
    logic       fin, prev_stall, prev_last;
    logic [7:0] prev_dout;
    logic [9:0] ahead;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = i[7:0];
        t2_addr = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        t2_dat  = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        pat     = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        rst = 1'b1; start = 1'b0; base = '0; len = '0; dout_ready = 1'b1;

        // reset state
        repeat (3) step();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_addr", ram_addr, 0);
        check("rst_valid", dout_valid, 0);
        check("rst_last", dout_last, 0);
        check("rst_dout", dout, 0);
`ifdef JTFRAME_RAM_STREAM_CHKSUM_EN
        check("rst_chk", chk, 0);
`endif
        rst = 1'b0;
        step();

        // basic: base 0x010 len 4, ready high
        do_start(10'h010, 11'd4);
        check("t1_busy", busy, 1);
        check("t1_addr_s1", ram_addr, 10'h010);
        check("t1_nvalid_s1", dout_valid, 0);
        step();
        check("t1_addr_s2", ram_addr, 10'h011);
        check("t1_nvalid_s2", dout_valid, 0);
        for (int k = 0; k < 4; k++) begin
            step();
            check("t1_valid", dout_valid, 1);
            check("t1_dout", dout, 8'h10 + 8'(k));
            check("t1_last", dout_last, (k == 3) ? 1 : 0);
            check("t1_ndone", done, 0);
        end
        step();
        check("t1_done", done, 1);
        check("t1_busy_off", busy, 0);
        check("t1_valid_off", dout_valid, 0);
        step();
        check("t1_done_pulse", done, 0);

        // wrap: base 0x3FE len 4
        do_start(10'h3FE, 11'd4);
        for (int k = 1; k <= 6; k++) begin
            if (k <= 4) check("t2_addr", ram_addr, t2_addr[k-1]);
            if (k >= 3) begin
                check("t2_valid", dout_valid, 1);
                check("t2_dout", dout, t2_dat[k-3]);
                check("t2_last", dout_last, (k == 6) ? 1 : 0);
            end
            step();
        end
        check("t2_done", done, 1);
        step();

        // backpressure: len 6, ready 1,0,0,1,0,1,1 from S+3
        acc = 0; fin = 1'b0; prev_stall = 1'b0; prev_dout = '0; prev_last = 1'b0;
        do_start(10'h020, 11'd6);
        for (int k = 1; k <= 40 && !fin; k++) begin
            dout_ready = (k >= 3 && k < 10) ? pat[k-3] : 1'b1;
            if (done) begin
                fin = 1'b1;
            end else begin
                if (prev_stall) begin
                    check("t3_hold_valid", dout_valid, 1);
                    check("t3_hold_dout", dout, prev_dout);
                    check("t3_hold_last", dout_last, prev_last);
                end
                ahead = ram_addr - 10'h020;
                check("t3_ahead", (32'(ahead) <= 32'(acc + 2)) ? 1 : 0, 1);
                if (dout_valid && dout_ready) begin
                    check("t3_dout", dout, 8'h20 + 8'(acc));
                    check("t3_last", dout_last, (acc == 5) ? 1 : 0);
                    acc++;
                end
                prev_stall = dout_valid && !dout_ready;
                prev_dout  = dout;
                prev_last  = dout_last;
                step();
            end
        end
        check("t3_done_seen", fin, 1);
        check("t3_count", acc, 6);
        dout_ready = 1'b1;
        step();

        // len 0: done at S+1, never busy or valid
        do_start(10'h005, 11'd0);
        check("t4_done", done, 1);
        check("t4_busy", busy, 0);
        check("t4_valid", dout_valid, 0);
        quiet = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (done || busy || dout_valid) quiet++;
        end
        check("t4_quiet", quiet, 0);

        // start while busy is ignored
        do_start(10'h040, 11'd3);
        check("t4b_busy", busy, 1);
        start = 1'b1; base = 10'h100; len = 11'd5;
        words = 0; dones = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            start = 1'b0;
            if (dout_valid && dout_ready) begin
                check("t4b_dout", dout, 8'h40 + 8'(words));
                words++;
            end
            if (done) dones++;
        end
        check("t4b_words", words, 3);
        check("t4b_dones", dones, 1);
        check("t4b_idle", busy, 0);

        // reset at S+4 of a len 8 transfer
        do_start(10'h080, 11'd8);
        repeat (3) step();
        rst = 1'b1;
        step();
        check("t5_busy", busy, 0);
        check("t5_done", done, 0);
        check("t5_addr", ram_addr, 0);
        check("t5_valid", dout_valid, 0);
        check("t5_last", dout_last, 0);
        check("t5_dout", dout, 0);
        rst = 1'b0;
        quiet = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (done || dout_valid || busy) quiet++;
        end
        check("t5_quiet", quiet, 0);
        do_start(10'h000, 11'd2);
        step();
        step();
        check("t5b_valid0", dout_valid, 1);
        check("t5b_dout0", dout, 8'h00);
        check("t5b_last0", dout_last, 0);
        step();
        check("t5b_dout1", dout, 8'h01);
        check("t5b_last1", dout_last, 1);
        step();
        check("t5b_done", done, 1);
        step();

`ifdef JTFRAME_RAM_STREAM_CHKSUM_EN
        // checksum: 0xFE+0xFF+0x00+0x01 mod 256
        do_start(10'h0FE, 11'd4);
        check("t6_clear", chk, 0);
        repeat (6) step();
        check("t6_done", done, 1);
        check("t6_chk", chk, 8'hFE);
        step();
        check("t6_chk_hold", chk, 8'hFE);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
